// File: rtl/branch_controller_if.sv
// Bundle of branch-resolution signals between the ID stage and branch_controller.
// master = pipeline side, slave = controller side.
interface branch_controller_if #(
  parameter int P_W  = 32,
  parameter int P_CW = 16
);
  logic            I_BRC_VALID;
  logic [1:0]      I_BRC_OP;
  logic [4:0]      I_BRC_RS;
  logic [4:0]      I_BRC_RT;
  logic [P_W-1:0]  I_BRC_A;
  logic [P_W-1:0]  I_BRC_B;
  logic [P_W-1:0]  I_BRC_PC4;
  logic [P_W-1:0]  I_BRC_IMM;
  logic            I_BRC_IDEX_WE;
  logic            I_BRC_IDEX_MEMREAD;
  logic [4:0]      I_BRC_IDEX_RD;
  logic            I_BRC_EXMEM_WE;
  logic            I_BRC_EXMEM_MEMREAD;
  logic [4:0]      I_BRC_EXMEM_RD;
  logic [P_W-1:0]  I_BRC_EXMEM_DATA;
  logic            I_BRC_COM_IGUAL;
  logic [P_W-1:0]  O_BRC_COM_A;
  logic [P_W-1:0]  O_BRC_COM_B;
  logic            O_BRC_STALL;
  logic            O_BRC_TAKEN;
  logic [P_W-1:0]  O_BRC_TARGET;
  logic            O_BRC_FLUSH;
  logic [P_CW-1:0] O_BRC_CNT_TAKEN;
  logic [P_CW-1:0] O_BRC_CNT_STALL;

  modport master (
    output I_BRC_VALID, I_BRC_OP, I_BRC_RS, I_BRC_RT, I_BRC_A, I_BRC_B,
           I_BRC_PC4, I_BRC_IMM, I_BRC_IDEX_WE, I_BRC_IDEX_MEMREAD, I_BRC_IDEX_RD,
           I_BRC_EXMEM_WE, I_BRC_EXMEM_MEMREAD, I_BRC_EXMEM_RD, I_BRC_EXMEM_DATA,
           I_BRC_COM_IGUAL,
    input  O_BRC_COM_A, O_BRC_COM_B, O_BRC_STALL, O_BRC_TAKEN, O_BRC_TARGET,
           O_BRC_FLUSH, O_BRC_CNT_TAKEN, O_BRC_CNT_STALL
  );

  modport slave (
    input  I_BRC_VALID, I_BRC_OP, I_BRC_RS, I_BRC_RT, I_BRC_A, I_BRC_B,
           I_BRC_PC4, I_BRC_IMM, I_BRC_IDEX_WE, I_BRC_IDEX_MEMREAD, I_BRC_IDEX_RD,
           I_BRC_EXMEM_WE, I_BRC_EXMEM_MEMREAD, I_BRC_EXMEM_RD, I_BRC_EXMEM_DATA,
           I_BRC_COM_IGUAL,
    output O_BRC_COM_A, O_BRC_COM_B, O_BRC_STALL, O_BRC_TAKEN, O_BRC_TARGET,
           O_BRC_FLUSH, O_BRC_CNT_TAKEN, O_BRC_CNT_STALL
  );
endinterface

// File: rtl/branch_controller.sv
// ID-stage branch resolution: operand forwarding, hazard stalls, registered
// redirect/flush and saturating taken/stall counters.
//
// state  | meaning
// S_IDLE | accepting a new branch; evaluates at once when no hazard
// S_WAIT | stalling on an operand; evaluates when cnt reaches 0
module branch_controller #(
  parameter int P_W  = 32,
  parameter int P_CW = 16
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  branch_controller_if.slave brc
);

  localparam logic [1:0] OP_BEQ  = 2'b00;
  localparam logic [1:0] OP_BNE  = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  logic [1:0]      op_q;
  logic [4:0]      rs_q, rt_q;
  logic            taken_q;
  logic [P_W-1:0]  target_q;
  logic [P_CW-1:0] cnt_taken_q, cnt_stall_q;

  logic [1:0]      op_cur;
  logic [4:0]      rs_cur, rt_cur;
  logic            idex_dep, exmem_dep, fwd_a, fwd_b;
  logic            accept, cond;
  logic [1:0]      depth;
  logic            stall, stall_out, eval, taken_now;
  logic [P_W-1:0]  target_now;

  function automatic logic dep(input logic we, input logic [4:0] rd, input logic [4:0] r);
    return we && (rd != 5'd0) && (rd == r);
  endfunction

  // While stalled the held instruction is taken from the registers latched on entry.
  assign op_cur = (state == S_WAIT) ? op_q : brc.I_BRC_OP;
  assign rs_cur = (state == S_WAIT) ? rs_q : brc.I_BRC_RS;
  assign rt_cur = (state == S_WAIT) ? rt_q : brc.I_BRC_RT;

  assign idex_dep  = dep(brc.I_BRC_IDEX_WE, brc.I_BRC_IDEX_RD, rs_cur) |
                     dep(brc.I_BRC_IDEX_WE, brc.I_BRC_IDEX_RD, rt_cur);
  assign exmem_dep = dep(brc.I_BRC_EXMEM_WE, brc.I_BRC_EXMEM_RD, rs_cur) |
                     dep(brc.I_BRC_EXMEM_WE, brc.I_BRC_EXMEM_RD, rt_cur);
  assign fwd_a = dep(brc.I_BRC_EXMEM_WE & ~brc.I_BRC_EXMEM_MEMREAD, brc.I_BRC_EXMEM_RD, rs_cur);
  assign fwd_b = dep(brc.I_BRC_EXMEM_WE & ~brc.I_BRC_EXMEM_MEMREAD, brc.I_BRC_EXMEM_RD, rt_cur);

  assign brc.O_BRC_COM_A = fwd_a ? brc.I_BRC_EXMEM_DATA : brc.I_BRC_A;
  assign brc.O_BRC_COM_B = fwd_b ? brc.I_BRC_EXMEM_DATA : brc.I_BRC_B;

  // The instruction in ID during a flush cycle is wrong-path and is dropped.
  assign accept = (state == S_IDLE) && brc.I_BRC_VALID && (brc.I_BRC_OP != OP_NONE) && !taken_q;
  assign cond   = (op_cur == OP_BEQ) || (op_cur == OP_BNE);

  always_comb begin
    depth = 2'd0;
    if (cond) begin
      if (idex_dep && brc.I_BRC_IDEX_MEMREAD)
        depth = 2'd2;
      else if (idex_dep || (exmem_dep && brc.I_BRC_EXMEM_MEMREAD))
        depth = 2'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    eval     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (depth != 2'd0) begin
            stall    = 1'b1;
            cnt_nx   = depth - 2'd1;
            state_nx = S_WAIT;
          end else begin
            eval = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 2'd0) begin
          stall  = 1'b1;
          cnt_nx = cnt - 2'd1;
        end else begin
          eval     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign stall_out  = stall & ~I_RST;
  assign taken_now  = eval && (((op_cur == OP_BEQ) &&  brc.I_BRC_COM_IGUAL) ||
                               ((op_cur == OP_BNE) && !brc.I_BRC_COM_IGUAL) ||
                                (op_cur == OP_B));
  assign target_now = brc.I_BRC_PC4 + (brc.I_BRC_IMM << 2);

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
      op_q  <= OP_NONE;
      rs_q  <= 5'd0;
      rt_q  <= 5'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op_q <= brc.I_BRC_OP;
        rs_q <= brc.I_BRC_RS;
        rt_q <= brc.I_BRC_RT;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      taken_q     <= 1'b0;
      target_q    <= '0;
      cnt_taken_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      taken_q  <= taken_now;
      target_q <= taken_now ? target_now : '0;
      if (taken_now && (cnt_taken_q != '1))
        cnt_taken_q <= cnt_taken_q + 1'b1;
      if (stall_out && (cnt_stall_q != '1))
        cnt_stall_q <= cnt_stall_q + 1'b1;
    end
  end

  assign brc.O_BRC_STALL     = stall_out;
  assign brc.O_BRC_TAKEN     = taken_q;
  assign brc.O_BRC_FLUSH     = taken_q;
  assign brc.O_BRC_TARGET    = target_q;
  assign brc.O_BRC_CNT_TAKEN = cnt_taken_q;
  assign brc.O_BRC_CNT_STALL = cnt_stall_q;

endmodule
